// File: rtl/i2c_txn_arbiter_if.sv
// Signal bundle between i2c_txn_arbiter, its requesters and the shared I2C master engine.
// Modport master is the arbiter's own view; slave is the surrounding requesters plus engine.
interface i2c_txn_arbiter_if #(
    parameter int NREQ = 2
);
    // Requester i holds req_valid[i] and its fields until the one-cycle req_ready[i]
    // accept pulse; fields are captured on that cycle only. rsp_valid[i] is a one-cycle
    // completion pulse, and m_start/m_done are single-cycle strobes in each direction.
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [7*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_sub;
    logic [NREQ-1:0]   req_rw;
    logic [3*NREQ-1:0] req_len;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              m_start;
    logic [6:0]        m_addr;
    logic [7:0]        m_sub;
    logic              m_rw;
    logic [2:0]        m_len;
    logic              m_busy;
    logic              m_done;
    logic              m_nack;
    logic [31:0]       m_rdata;

    modport master (
        input  req_valid, req_addr, req_sub, req_rw, req_len,
        input  m_busy, m_done, m_nack, m_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output m_start, m_addr, m_sub, m_rw, m_len
    );

    modport slave (
        output req_valid, req_addr, req_sub, req_rw, req_len,
        output m_busy, m_done, m_nack, m_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  m_start, m_addr, m_sub, m_rw, m_len
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master engine between NREQ requesters.
// Define I2C_ARB_TIMEOUT_EN to add a 16-bit WAIT watchdog that reports a timeout error.
module i2c_txn_arbiter #(
    parameter int NREQ   = 2,
    parameter int MAXLEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    i2c_txn_arbiter_if.master bus,
    output logic [1:0]        fsm_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, state_n;

    logic [1:0]      rr, gnt, pick;
    logic            pick_found;
    logic [2:0]      k, len_raw, pick_len;
    logic [3:0]      valid_p, rw_p;
    logic [27:0]     addr_p;
    logic [31:0]     sub_p;
    logic [11:0]     len_p;
    logic            done_ok, timeout;
    logic [31:0]     rd_mask;

    logic [NREQ-1:0] req_ready_q, rsp_valid_q;
    logic            m_start_q, m_rw_q, rsp_err_q;
    logic [6:0]      m_addr_q;
    logic [7:0]      m_sub_q;
    logic [2:0]      m_len_q;
    logic [31:0]     rsp_data_q;

    // Request vectors padded to four slots so every index is 2 bits wide.
    always_comb begin
        valid_p = '0;
        rw_p    = '0;
        addr_p  = '0;
        sub_p   = '0;
        len_p   = '0;
        valid_p[NREQ-1:0]   = bus.req_valid;
        rw_p[NREQ-1:0]      = bus.req_rw;
        addr_p[7*NREQ-1:0]  = bus.req_addr;
        sub_p[8*NREQ-1:0]   = bus.req_sub;
        len_p[3*NREQ-1:0]   = bus.req_len;
    end

    always_comb begin
        pick       = rr;
        pick_found = 1'b0;
        k          = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = {1'b0, rr} + 3'(i);
            if (k >= 3'(NREQ)) k = k - 3'(NREQ);
            if (!pick_found && valid_p[k[1:0]]) begin
                pick_found = 1'b1;
                pick       = k[1:0];
            end
        end
    end

    // Writes carry no read bytes; out-of-range read lengths fall back to MAXLEN.
    always_comb begin
        len_raw = len_p[3*pick +: 3];
        if (!rw_p[pick])
            pick_len = 3'd0;
        else if (len_raw == 3'd0 || int'(len_raw) > MAXLEN)
            pick_len = 3'(MAXLEN);
        else
            pick_len = len_raw;
    end

    // The first WAIT cycle carries m_start, so a completion seen there cannot be ours.
    assign done_ok = (state == WAIT) && bus.m_done && !m_start_q;
    assign rd_mask = ~(32'hFFFF_FFFF >> {m_len_q, 3'b000});

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] wdog;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wdog <= '0;
        else if (state != WAIT)
            wdog <= '0;
        else
            wdog <= wdog + 16'd1;
    end

    assign timeout = (state == WAIT) && (wdog == 16'hFFFE);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!bus.m_busy && pick_found) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (done_ok || timeout) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr          <= '0;
            gnt         <= '0;
            req_ready_q <= '0;
            m_start_q   <= 1'b0;
            m_addr_q    <= '0;
            m_sub_q     <= '0;
            m_rw_q      <= 1'b0;
            m_len_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            req_ready_q <= '0;
            m_start_q   <= 1'b0;
            rsp_valid_q <= '0;
            case (state)
                IDLE: if (state_n == ISSUE) begin
                    gnt         <= pick;
                    req_ready_q <= NREQ'(1) << pick;
                    m_addr_q    <= addr_p[7*pick +: 7];
                    m_sub_q     <= sub_p[8*pick +: 8];
                    m_rw_q      <= rw_p[pick];
                    m_len_q     <= pick_len;
                end
                ISSUE: m_start_q <= 1'b1;
                WAIT: if (state_n == RESP) begin
                    rsp_valid_q <= NREQ'(1) << gnt;
                    if (done_ok) begin
                        rsp_data_q <= bus.m_rdata & rd_mask;
                        rsp_err_q  <= bus.m_nack;
                    end else begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                RESP: rr <= (gnt == 2'(NREQ-1)) ? 2'd0 : gnt + 2'd1;
                default: ;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.m_start   = m_start_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_sub     = m_sub_q;
    assign bus.m_rw      = m_rw_q;
    assign bus.m_len     = m_len_q;
    assign fsm_state     = state;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: directed cases followed by randomized traffic against a
// transaction-level model (round-robin pick, length clamp, byte masking).
`timescale 1ns/1ps
module tb_i2c_txn_arbiter;
    localparam int NREQ   = 2;
    localparam int MAXLEN = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    int         m_rr;
    bit         p_valid[NREQ];
    logic [6:0] p_addr[NREQ];
    logic [7:0] p_sub[NREQ];
    logic       p_rw[NREQ];
    logic [2:0] p_len[NREQ];
    int         rem[NREQ];
    int         g;

    i2c_txn_arbiter_if #(.NREQ(NREQ)) bus ();

    i2c_txn_arbiter #(.NREQ(NREQ), .MAXLEN(MAXLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // reference model
    function automatic logic [31:0] onehot(input int i);
        return 32'd1 << i;
    endfunction

    function automatic logic [2:0] exp_len(input logic rw, input logic [2:0] len);
        if (!rw) return 3'd0;
        if (len == 3'd0 || int'(len) > MAXLEN) return 3'(MAXLEN);
        return len;
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] rd, input logic [2:0] n);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++)
            if (b < int'(n)) r[31-8*b -: 8] = rd[31-8*b -: 8];
        return r;
    endfunction

    function automatic int model_pick();
        for (int i = 0; i < NREQ; i++)
            if (p_valid[(m_rr + i) % NREQ]) return (m_rr + i) % NREQ;
        return -1;
    endfunction

    function automatic bit any_valid();
        for (int i = 0; i < NREQ; i++) if (p_valid[i]) return 1'b1;
        return 1'b0;
    endfunction

    // drivers
    task automatic init_inputs();
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_sub   = '0;
        bus.req_rw    = '0;
        bus.req_len   = '0;
        bus.m_busy    = 1'b0;
        bus.m_done    = 1'b0;
        bus.m_nack    = 1'b0;
        bus.m_rdata   = '0;
        m_rr = 0;
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) begin
            p_valid[i] = 1'b0;
            rem[i]     = 0;
        end
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_data"}, bus.rsp_data, 32'd0);
        check_val({tag, "_ctl"}, 32'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.m_start,
                  bus.m_addr, bus.m_sub, bus.m_rw, bus.m_len, fsm_state}), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        init_inputs();
        repeat (2) @(negedge clk);
        check_quiet("reset");
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic post(input int i, input logic [6:0] a, input logic [7:0] s,
                        input logic rw, input logic [2:0] len, input int cnt);
        p_valid[i] = 1'b1;
        p_addr[i]  = a;
        p_sub[i]   = s;
        p_rw[i]    = rw;
        p_len[i]   = len;
        rem[i]     = cnt;
        bus.req_addr[7*i +: 7] = a;
        bus.req_sub[8*i +: 8]  = s;
        bus.req_rw[i]          = rw;
        bus.req_len[3*i +: 3]  = len;
        bus.req_valid[i]       = 1'b1;
    endtask

    // One full transaction from an IDLE arbiter with at least one request posted.
    task automatic serve_one(input int dly, input logic [31:0] rd, input logic nk,
                             input bit spur, output int gg);
        int eg;
        logic [2:0] el;
        logic [31:0] ed;
        eg = model_pick();
        gg = -1;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++)
            if (bus.req_ready[i] && $onehot(bus.req_ready)) gg = i;
        check_val("req_ready", 32'(bus.req_ready), onehot(eg));
        el = exp_len(p_rw[eg], p_len[eg]);
        check_val("m_addr", 32'(bus.m_addr), 32'(p_addr[eg]));
        check_val("m_sub", 32'(bus.m_sub), 32'(p_sub[eg]));
        check_val("m_rw", 32'(bus.m_rw), 32'(p_rw[eg]));
        check_val("m_len", 32'(bus.m_len), 32'(el));
        check_val("start_early", 32'(bus.m_start), 32'd0);
        rem[eg]--;
        if (rem[eg] <= 0) begin
            p_valid[eg] = 1'b0;
            bus.req_valid[eg] = 1'b0;
        end
        @(negedge clk);
        check_val("m_start", 32'(bus.m_start), 32'd1);
        check_val("ready_pulse", 32'(bus.req_ready), 32'd0);
        bus.m_busy = 1'b1;
        if (spur) begin
            bus.m_done  = 1'b1;
            bus.m_nack  = 1'b1;
            bus.m_rdata = $urandom;
        end
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            bus.m_done = 1'b0;
            check_val("start_once", 32'(bus.m_start), 32'd0);
            check_val("rsp_early", 32'(bus.rsp_valid), 32'd0);
        end
        bus.m_done  = 1'b1;
        bus.m_rdata = rd;
        bus.m_nack  = nk;
        exp_q.push_back(model_data(rd, el));
        @(negedge clk);
        bus.m_done  = 1'b0;
        bus.m_busy  = 1'b0;
        bus.m_nack  = 1'b0;
        bus.m_rdata = $urandom;
        ed = exp_q.pop_front();
        check_val("rsp_valid", 32'(bus.rsp_valid), onehot(eg));
        check_val("rsp_data", bus.rsp_data, ed);
        check_val("rsp_err", 32'(bus.rsp_err), 32'(nk));
        m_rr = (eg + 1) % NREQ;
        @(negedge clk);
        check_val("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
        check_val("rsp_hold", bus.rsp_data, ed);
        check_val("err_hold", 32'(bus.rsp_err), 32'(nk));
    endtask

    initial begin
        reset = 1'b0;
        init_inputs();
        do_reset();

        // fairness: both requesters hold two transactions each
        post(0, 7'h11, 8'hA0, 1'b1, 3'd3, 2);
        post(1, 7'h22, 8'hB0, 1'b1, 3'd1, 2);
        for (int t = 0; t < 4; t++) begin
            serve_one(2, $urandom, 1'b0, 1'b0, g);
            check_val("fair_order", 32'(g), 32'(t % 2));
        end

        // single read
        post(0, 7'h48, 8'h01, 1'b1, 3'd2, 1);
        serve_one(3, 32'hABCD_1234, 1'b0, 1'b1, g);
        check_val("single_data", bus.rsp_data, 32'hABCD_0000);

        // NACK on a write
        post(1, 7'h2C, 8'h10, 1'b0, 3'd3, 1);
        serve_one(2, 32'h5A5A_5A5A, 1'b1, 1'b0, g);
        check_val("nack_err", 32'(bus.rsp_err), 32'd1);
        check_val("nack_data", bus.rsp_data, 32'd0);

        // length clamp
        post(0, 7'h30, 8'h04, 1'b1, 3'd0, 1);
        serve_one(1, 32'h0102_0304, 1'b0, 1'b0, g);
        post(1, 7'h31, 8'h05, 1'b1, 3'd7, 1);
        serve_one(1, 32'hF0E0_D0C0, 1'b0, 1'b0, g);

        // busy master blocks the grant
        bus.m_busy = 1'b1;
        post(0, 7'h55, 8'h66, 1'b1, 3'd1, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("busy_ready", 32'(bus.req_ready), 32'd0);
            check_val("busy_start", 32'(bus.m_start), 32'd0);
        end
        bus.m_busy = 1'b0;
        serve_one(2, 32'h99AA_BBCC, 1'b0, 1'b0, g);

        // reset in the middle of WAIT
        post(1, 7'h0F, 8'h33, 1'b1, 3'd4, 1);
        @(negedge clk);
        check_val("mid_ready", 32'(bus.req_ready), onehot(1));
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        bus.m_busy = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_quiet("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        init_inputs();
        bus.m_done = 1'b1;
        @(negedge clk);
        bus.m_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("post_reset_rsp", 32'(bus.rsp_valid), 32'd0);
            check_val("post_reset_state", 32'(fsm_state), 32'd0);
        end

`ifdef I2C_ARB_TIMEOUT_EN
        post(1, 7'h44, 8'h02, 1'b1, 3'd3, 1);
        @(negedge clk);
        check_val("to_ready", 32'(bus.req_ready), onehot(1));
        bus.req_valid[1] = 1'b0;
        p_valid[1] = 1'b0;
        @(negedge clk);
        check_val("to_start", 32'(bus.m_start), 32'd1);
        bus.m_busy = 1'b1;
        for (int j = 1; j < 65535; j++) @(negedge clk);
        check_val("to_early", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check_val("to_valid", 32'(bus.rsp_valid), onehot(1));
        check_val("to_err", 32'(bus.rsp_err), 32'd1);
        check_val("to_data", bus.rsp_data, 32'd0);
        m_rr = 0;
        bus.m_done  = 1'b1;
        bus.m_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.m_done = 1'b0;
        bus.m_busy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_val("late_done", 32'(bus.rsp_valid), 32'd0);
            check_val("late_state", 32'(fsm_state), 32'd0);
        end
`endif

        // randomized traffic
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NREQ; i++)
                if (!p_valid[i] && $urandom_range(0, 1) == 1)
                    post(i, 7'($urandom), 8'($urandom), 1'($urandom), 3'($urandom), 1);
            if (!any_valid())
                post($urandom_range(0, NREQ-1), 7'($urandom), 8'($urandom), 1'($urandom),
                     3'($urandom), 1);
            serve_one($urandom_range(1, 5), $urandom, 1'($urandom_range(0, 3) == 0),
                      $urandom_range(0, 3) == 0, g);
            if ($urandom_range(0, 4) == 0) begin
                for (int i = 0; i < NREQ; i++)
                    if (p_valid[i]) begin
                        p_valid[i] = 1'b0;
                        rem[i] = 0;
                        bus.req_valid[i] = 1'b0;
                        break;
                    end
            end
        end
        for (int i = 0; i < NREQ; i++)
            if (any_valid()) serve_one(1, $urandom, 1'b0, 1'b0, g);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one I2C master engine between NREQ independent requesters, e.g. the sensor poller and the host register path.
- Each requester presents a complete transaction: 7-bit device address, 8-bit sub-address, rw, byte count.
- The block grants requesters round-robin and launches the transaction on the master's command port.
- It waits for completion, then returns read data and ACK status to the granted requester only.

Parameters:
- NREQ, 2, number of requesters (2..4).
- MAXLEN, 4, maximum bytes per transaction (1..4); read data is packed into 32 bits.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester transaction request
- req_ready  output  NREQ  one-hot accept pulse for the granted requester
- req_addr  input  7*NREQ  device address, requester i at [7i+6:7i]
- req_sub  input  8*NREQ  sub-address, requester i at [8i+7:8i]
- req_rw  input  NREQ  0 = write sub-address only, 1 = sub-address write then repeated-start read
- req_len  input  3*NREQ  read byte count, 1..MAXLEN
- rsp_valid  output  NREQ  one-hot, one-cycle completion pulse
- rsp_data  output  32  read bytes, first byte in [31:24]; unused bytes are zero
- rsp_err  output  1  NACK or timeout; valid while rsp_valid is high
- m_start  output  1  one-cycle launch pulse to the master
- m_addr  output  7  latched address
- m_sub  output  8  latched sub-address
- m_rw  output  1  latched rw
- m_len  output  3  latched length
- m_busy  input  1  master transaction in progress
- m_done  input  1  one-cycle completion from the master
- m_nack  input  1  master saw NACK; sampled with m_done
- m_rdata  input  32  master read data; sampled with m_done

Behaviour:
- Reset (reset=0): state IDLE, rr pointer=0, all outputs 0, latched command registers 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Stay while m_busy=1 or no req_valid is set.
  - Otherwise pick the first requester with req_valid set, searching from rr pointer upward with wrap modulo NREQ.
  - Pulse req_ready[g] for one cycle, latch that requester's addr, sub, rw and len into m_*, then go to ISSUE.
- Length handling: req_len of 0 or above MAXLEN is clamped to MAXLEN. When rw=0, len is ignored and m_len is 0.
- ISSUE: m_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On m_done, capture m_rdata, masking unread low bytes to zero, and capture m_nack, then go to RESP.
  - m_done in the same cycle as m_start is ignored.
- RESP:
  - One cycle: rsp_valid[g]=1, rsp_data and rsp_err driven.
  - Advance rr pointer to g+1 mod NREQ, return to IDLE.
  - rsp_data and rsp_err hold their values until the next RESP.
- Latency:
  - req_valid to req_ready is 1 cycle when IDLE and the master is idle.
  - req_ready to m_start is 1 cycle.
  - m_done to rsp_valid is 1 cycle.
  - Minimum back-to-back gap is IDLE→IDLE, one cycle.
- Requester rules:
  - req_valid must hold until req_ready.
  - A requester that drops req_valid before grant loses nothing.
  - Request fields are sampled only on the req_ready cycle.
- Simultaneous requests: exactly one grant per arbitration; no requester waits more than NREQ-1 grants.
- Reset mid-transaction: returns to IDLE immediately. No rsp_valid is issued. Master sequencing is the master's own reset responsibility.
- Spurious m_done outside WAIT is ignored.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Enabled:
  - A 16-bit watchdog counts cycles in WAIT and loads 0 on entry to WAIT.
  - If it reaches 16'hFFFF before m_done, go to RESP with rsp_err=1 and rsp_data=0.
  - A late m_done is then ignored.
- Disabled: no counter; WAIT holds indefinitely until m_done.

Test Plan:
- Single read: req0 addr=7'h48, sub=8'h01, rw=1, len=2. Master returns m_rdata=32'hABCD_1234, nack=0 → m_start once with m_addr=7'h48, m_sub=8'h01, m_len=2. rsp_valid=2'b01, rsp_data=32'hABCD_0000, rsp_err=0.
- Fairness: req0 and req1 held continuously for 4 transactions → grant order 0,1,0,1; each rsp_valid goes only to its own requester.
- NACK: write rw=0 with m_nack=1 at m_done → rsp_err=1, rsp_data=0, m_len=0.
- Clamp: req_len=0 and req_len=7 with MAXLEN=4 → m_len=4 in both cases.
- Busy master: m_busy=1 while req_valid=1 → no req_ready and no m_start until m_busy=0, then grant on the next cycle.
- Reset mid-WAIT: drive reset=0 for 1 cycle during WAIT → all outputs 0, state IDLE, no rsp_valid. With I2C_ARB_TIMEOUT_EN, withhold m_done → rsp_err=1 exactly 65535 cycles after WAIT entry.
